// File: rtl/block_input.sv
// rtl/block_input.sv - router input-port buffer: flit FIFO, head decode, route request, packet forwarding
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   Data_in    flit from the upstream link ([7:6] type, [5:0] payload)
//   val        upstream flit valid
//   ret        ready to accept (upstream flow-control return), = ~full
//   Data_out   FIFO front toward the crossbar, 0 when empty
//   out_val    Data_out valid
//   out_rdy    crossbar accepts Data_out
//   route_req  requesting an output port from the switch allocator
//   dest       destination {x[1:0], y[1:0]} of the current packet
//   grant      allocator grant, sampled while route_req=1
//   full       FIFO holds DEPTH flits
//   err        one-cycle pulse on an orphan flit or a missing tail

module block_input #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] Data_in,
  input  logic          val,
  output logic          ret,
  output logic [DW-1:0] Data_out,
  output logic          out_val,
  input  logic          out_rdy,
  output logic          route_req,
  output logic [3:0]    dest,
  input  logic          grant,
  output logic          full,
  output logic          err
);

  localparam logic [1:0] T_HEAD = 2'b11;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_IDLE = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HEAD = 2'd2,
    S_BODY = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic [DW-1:0] front;
  logic [1:0]    front_type;
  logic          push, pop;
  logic          err_set;
  logic          dest_load;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  // No lookahead: a pop in the same cycle does not reopen the link.
  assign ret        = ~full;
  assign front      = mem[rd_ptr];
  assign front_type = front[DW-1:DW-2];
  assign Data_out   = empty ? '0 : front;
  // Idle flits are link filler and are never stored.
  assign push       = val & ret & (Data_in[DW-1:DW-2] != T_IDLE);

  // Storage has no reset; Data_out masks stale entries via the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      dest  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_set;
      if (dest_load) dest <= front[3:0];
    end
  end

  always_comb begin
    state_nxt = state;
    route_req = 1'b0;
    out_val   = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    dest_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (front_type == T_HEAD) begin
            dest_load = 1'b1;
            state_nxt = S_REQ;
          end else begin
            // Orphan body/tail with no head in front of it: discard.
            pop     = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      S_REQ: begin
        route_req = 1'b1;
        if (grant) state_nxt = S_HEAD;
      end
      S_HEAD: begin
        route_req = 1'b1;
        out_val   = 1'b1;
        if (out_rdy) begin
          pop       = 1'b1;
          state_nxt = S_BODY;
        end
      end
      S_BODY: begin
        route_req = 1'b1;
        if (!empty && front_type == T_HEAD) begin
          // Missing tail: leave the new head queued for a fresh request.
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          out_val = ~empty;
          if (out_val && out_rdy) begin
            pop = 1'b1;
            if (front_type == T_TAIL) state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_input.sv
// tb/tb_block_input.sv - directed self-checking bench for block_input
module tb_block_input;

  logic       clk;
  logic       rst;
  logic [7:0] Data_in;
  logic       val;
  logic       ret;
  logic [7:0] Data_out;
  logic       out_val;
  logic       out_rdy;
  logic       route_req;
  logic [3:0] dest;
  logic       grant;
  logic       full;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  block_input #(.DW(8), .DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .Data_in  (Data_in),
    .val      (val),
    .ret      (ret),
    .Data_out (Data_out),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .route_req(route_req),
    .dest     (dest),
    .grant    (grant),
    .full     (full),
    .err      (err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    val = 1'b0; Data_in = 8'h00; out_rdy = 1'b0; grant = 1'b0;
    rst = 1'b0;
    #7;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; val = 1'b0; Data_in = 8'h00; out_rdy = 1'b0; grant = 1'b0;
    #25;
    rst = 1'b1;
    tick();
    n_cmp++; if (ret !== 1'b1)       begin n_bad++; $display("FAIL reset_ret got=%b exp=1", ret); end
    n_cmp++; if (full !== 1'b0)      begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (out_val !== 1'b0)   begin n_bad++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
    n_cmp++; if (route_req !== 1'b0) begin n_bad++; $display("FAIL reset_route_req got=%b exp=0", route_req); end
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (Data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got=%h exp=00", Data_out); end
    n_cmp++; if (dest !== 4'h0)      begin n_bad++; $display("FAIL reset_dest got=%h exp=0", dest); end
  endtask

  task automatic test_basic_packet();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hFA; exp_d[1] = 8'h85; exp_d[2] = 8'h41;
    do_reset();
    out_rdy = 1'b1;
    val = 1'b1; Data_in = 8'hFA;
    tick();
    n_cmp++; if (route_req !== 1'b0) begin n_bad++; $display("FAIL basic_req_early got=%b exp=0", route_req); end
    Data_in = 8'h85;
    tick();
    n_cmp++; if (route_req !== 1'b1) begin n_bad++; $display("FAIL basic_req got=%b exp=1", route_req); end
    n_cmp++; if (dest !== 4'hA)      begin n_bad++; $display("FAIL basic_dest got=%h exp=a", dest); end
    n_cmp++; if (out_val !== 1'b0)   begin n_bad++; $display("FAIL basic_outval_req got=%b exp=0", out_val); end
    Data_in = 8'h41; grant = 1'b1;
    tick();
    val = 1'b0; grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_val !== 1'b1 || Data_out !== exp_d[i]) begin
        n_bad++; $display("FAIL basic_flit%0d got=%b/%h exp=1/%h", i, out_val, Data_out, exp_d[i]);
      end
      tick();
    end
    n_cmp++; if (route_req !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop got=%b exp=0", route_req); end
    n_cmp++; if (out_val !== 1'b0 || Data_out !== 8'h00) begin
      n_bad++; $display("FAIL basic_empty got=%b/%h exp=0/00", out_val, Data_out);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] flits [5];
    flits[0] = 8'hFA; flits[1] = 8'h85; flits[2] = 8'h86; flits[3] = 8'h87; flits[4] = 8'h41;
    do_reset();
    val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Data_in = flits[i];
      tick();
    end
    n_cmp++; if (full !== 1'b1 || ret !== 1'b0) begin
      n_bad++; $display("FAIL bp_full got=%b/%b exp=1/0", full, ret);
    end
    Data_in = flits[4];
    tick();
    n_cmp++; if (full !== 1'b1 || ret !== 1'b0) begin
      n_bad++; $display("FAIL bp_hold got=%b/%b exp=1/0", full, ret);
    end
    grant = 1'b1; out_rdy = 1'b1;
    tick();
    n_cmp++; if (out_val !== 1'b1 || Data_out !== 8'hFA || ret !== 1'b0) begin
      n_bad++; $display("FAIL bp_head got=%b/%h/%b exp=1/fa/0", out_val, Data_out, ret);
    end
    tick();
    n_cmp++; if (ret !== 1'b1) begin n_bad++; $display("FAIL bp_ret_back got=%b exp=1", ret); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (out_val !== 1'b1 || Data_out !== flits[i]) begin
        n_bad++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, out_val, Data_out, flits[i]);
      end
      tick();
      val = 1'b0;
    end
    n_cmp++; if (out_val !== 1'b0 || route_req !== 1'b0 || Data_out !== 8'h00) begin
      n_bad++; $display("FAIL bp_done got=%b/%b/%h exp=0/0/00", out_val, route_req, Data_out);
    end
    grant = 1'b0;
  endtask

  task automatic test_idle_orphan();
    do_reset();
    val = 1'b1; Data_in = 8'h00;
    tick();
    n_cmp++; if (out_val !== 1'b0 || Data_out !== 8'h00) begin
      n_bad++; $display("FAIL idle_drop got=%b/%h exp=0/00", out_val, Data_out);
    end
    Data_in = 8'h85;
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL idle_no_err got=%b exp=0", err); end
    Data_in = 8'hC3;
    tick();
    val = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL orphan_err got=%b exp=1", err); end
    n_cmp++; if (Data_out !== 8'hC3) begin n_bad++; $display("FAIL orphan_front got=%h exp=c3", Data_out); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL orphan_err_pulse got=%b exp=0", err); end
    n_cmp++; if (route_req !== 1'b1 || dest !== 4'h3) begin
      n_bad++; $display("FAIL orphan_req got=%b/%h exp=1/3", route_req, dest);
    end
  endtask

  task automatic test_missing_tail();
    do_reset();
    out_rdy = 1'b1;
    val = 1'b1; Data_in = 8'hFA;
    tick();
    Data_in = 8'h85;
    tick();
    Data_in = 8'hFB; grant = 1'b1;
    tick();
    val = 1'b0; grant = 1'b0;
    n_cmp++; if (out_val !== 1'b1 || Data_out !== 8'hFA) begin
      n_bad++; $display("FAIL mt_head got=%b/%h exp=1/fa", out_val, Data_out);
    end
    tick();
    n_cmp++; if (out_val !== 1'b1 || Data_out !== 8'h85) begin
      n_bad++; $display("FAIL mt_body got=%b/%h exp=1/85", out_val, Data_out);
    end
    tick();
    n_cmp++; if (out_val !== 1'b0 || route_req !== 1'b1) begin
      n_bad++; $display("FAIL mt_stall got=%b/%b exp=0/1", out_val, route_req);
    end
    tick();
    n_cmp++; if (err !== 1'b1 || route_req !== 1'b0 || dest !== 4'hA) begin
      n_bad++; $display("FAIL mt_err got=%b/%b/%h exp=1/0/a", err, route_req, dest);
    end
    tick();
    n_cmp++; if (err !== 1'b0 || route_req !== 1'b1 || dest !== 4'hB) begin
      n_bad++; $display("FAIL mt_rereq got=%b/%b/%h exp=0/1/b", err, route_req, dest);
    end
    tick();
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL mt_wait_grant got=%b exp=0", out_val); end
    grant = 1'b1;
    tick();
    grant = 1'b0;
    n_cmp++; if (out_val !== 1'b1 || Data_out !== 8'hFB) begin
      n_bad++; $display("FAIL mt_fb got=%b/%h exp=1/fb", out_val, Data_out);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    grant = 1'b1;
    val = 1'b1; Data_in = 8'hFA;
    tick();
    Data_in = 8'h85;
    tick();
    Data_in = 8'h86;
    tick();
    val = 1'b0; grant = 1'b0; out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    n_cmp++; if (out_val !== 1'b1 || Data_out !== 8'h85) begin
      n_bad++; $display("FAIL rmp_body got=%b/%h exp=1/85", out_val, Data_out);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (route_req !== 1'b0 || out_val !== 1'b0 || Data_out !== 8'h00) begin
      n_bad++; $display("FAIL rmp_async got=%b/%b/%h exp=0/0/00", route_req, out_val, Data_out);
    end
    n_cmp++; if (ret !== 1'b1 || full !== 1'b0 || dest !== 4'h0 || err !== 1'b0) begin
      n_bad++; $display("FAIL rmp_async2 got=%b/%b/%h/%b exp=1/0/0/0", ret, full, dest, err);
    end
    #10;
    rst = 1'b1;
    out_rdy = 1'b1; grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (out_val !== 1'b0 || Data_out !== 8'h00 || route_req !== 1'b0) begin
        n_bad++; $display("FAIL rmp_stale%0d got=%b/%h/%b exp=0/00/0", i, out_val, Data_out, route_req);
      end
    end
    out_rdy = 1'b0; grant = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_backpressure();
    test_idle_orphan();
    test_missing_tail();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_input.md
Name: block_input

Overview:
- Router input-port buffer; the receiving end of the flit link driven by the output block of a neighbouring router.
- Accepts 8-bit flits under the val/ret handshake and stores them in a small FIFO.
- Decodes each head flit's destination and raises a route request toward the switch allocator.
- After a grant, forwards the packet's flits to the crossbar until the tail flit has been sent.

Parameters:
- DW, 8, flit width. Flit format: [7:6] type; [5:0] payload.
- Flit types: 2'b11 head, 2'b10 body, 2'b01 tail, 2'b00 idle.
- DEPTH, 4, FIFO depth in flits. Must be a power of 2, at least 2.
- AW, 2, pointer width. Equals log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- Data_in  in  DW  flit from the upstream link.
- val  in  1  upstream flit valid.
- ret  out  1  ready to accept; this is the upstream flow-control return.
- Data_out  out  DW  flit to the crossbar.
- out_val  out  1  Data_out valid.
- out_rdy  in  1  crossbar accepts Data_out.
- route_req  out  1  requesting an output port.
- dest  out  4  destination of the current packet; {x[1:0], y[1:0]} = head payload [3:0].
- grant  in  1  allocator grant; sampled while route_req=1.
- full  out  1  FIFO holds DEPTH flits.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count go to 0; state goes to IDLE; dest=0.
  - Outputs: route_req=0, out_val=0, err=0, full=0, ret=1.
  - Data_out=0 while empty.
  - Reset mid-packet discards all buffered flits; no partial flit is ever output.
- FIFO:
  - ret = ~full, combinational from the registered count. There is no lookahead: when full, ret=0 even if a pop happens in the same cycle.
  - Push when val & ret & (Data_in[7:6] != 2'b00). Idle flits are silently dropped and never stored.
  - Pop when (out_val & out_rdy), or on a discard in IDLE (see below).
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Data_out = FIFO front, combinational; 0 when empty.
  - Latency: a flit pushed at edge N is visible at the front after edge N when the FIFO was empty. It reaches out_val no earlier than edge N+2, because the request and grant stages intervene for heads.
- State machine (state is registered):
  - IDLE:
    - If not empty and the front is a head: dest <= front[3:0], go to REQ.
    - If not empty and the front is body or tail (orphan): pop it, pulse err, stay in IDLE.
  - REQ:
    - route_req=1, dest held, out_val=0.
    - On grant=1 at an edge, go to HEAD. Otherwise wait indefinitely.
  - HEAD:
    - route_req=1, out_val=1 (the front is the head).
    - On out_rdy, pop and go to BODY.
  - BODY:
    - route_req=1, out_val = ~empty & (front type != head).
    - On out_rdy with front = tail: pop and go to IDLE. route_req drops the following cycle.
    - If the front is a head (missing tail): no pop, pulse err, drop route_req, go to IDLE. That head is then processed normally.
- Single-flit packets are not supported; a packet is at least a head plus a tail.
- err is registered and high for exactly one cycle per event.
- dest changes only on the IDLE to REQ transition.

Test Plan:
- Reset then idle: rst=0 for 25 ns, then release, with val=0 → ret=1, full=0, out_val=0, route_req=0, err=0, Data_out=8'h00.
- Basic packet:
  - Stimulus: push 8'hFA (head, dest 4'b1010), 8'h85, 8'h41, with grant=1 one cycle after route_req and out_rdy=1.
  - Response: dest=4'hA; route_req=1 from the cycle after the head lands; Data_out sequence FA, 85, 41 on consecutive out_val cycles; route_req=0 the cycle after 41 pops.
- Backpressure / full:
  - Stimulus: out_rdy=0, grant=0, push five non-idle flits with val held high.
  - Response: full=1 and ret=0 after the fourth push; the fifth flit is not stored until a pop.
  - Then raise grant and out_rdy: all flits drain in order, and ret returns to 1 the cycle after the first pop.
- Idle filtering and orphans:
  - Push 8'h00, then 8'h85, then 8'hC3 → 00 is never stored; 85 is discarded with a single err pulse; C3 triggers route_req with dest=4'h3.
- Missing tail:
  - Push FA, 85, then head FB (no tail between them).
  - After 85 is forwarded: err pulses, route_req drops for one cycle, then re-asserts with dest=4'hB; FB is forwarded only after a new grant.
- Reset mid-packet:
  - Assert rst while in BODY with 2 flits buffered.
  - Response: outputs return to reset values immediately, without waiting for a clock edge; after release, no stale flit appears on Data_out.
